ds_loader: RTL and testbench
============================

Name: ds_loader

Overview:
- Source side of the datapath's S-select path: buffers externally supplied 16-bit words with a destination register address.
- Sequences each word into the datapath by driving DS, S_Sel and a register-file write strobe.
- Sits between the switch/load front end and the integer datapath.
- Guarantees DS is stable before S_Sel rises and stays stable until S_Sel falls, so the S-select mux always passes a settled value.

Parameters:
- DATA_W, 16, width of DS and of buffered data words
- DEPTH, 4, buffer entries (power of two)
- ADDR_W, 3, register-file destination address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wr_en  in  1  push request for {wr_addr, wr_data}
- wr_data  in  DATA_W  word to load
- wr_addr  in  ADDR_W  destination register for the word
- go  in  1  datapath grants a load slot (level, sampled in IDLE only)
- DS  out  DATA_W  data presented to the S-select mux
- S_Sel  out  1  1 = datapath selects DS, 0 = normal S path
- W_En  out  1  register-file write strobe
- W_Adr  out  ADDR_W  register-file write address
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  clog2(DEPTH)+1  occupied entries
- busy  out  1  FSM not in IDLE
- overflow  out  1  sticky: push attempted while full

Behaviour:
- All outputs registered.
- Reset values: DS=0, S_Sel=0, W_En=0, W_Adr=0, count=0, empty=1, full=0, busy=0, overflow=0, FSM=IDLE, read/write pointers=0.
- Buffer: circular FIFO of {addr,data}, DEPTH entries; pointers wrap modulo DEPTH.
- Push: wr_en & !full stores the entry and increments count.
- Push when full: entry dropped, overflow set; overflow is cleared only by reset.
- Pop occurs only in RELEASE. A push and a pop in the same cycle leave count unchanged, and both take effect.
- FSM states: IDLE, SETUP, SELECT, WRITE, RELEASE.
- IDLE: S_Sel=0, W_En=0. If !empty & go, load DS and W_Adr from the head entry, then go to SETUP. Otherwise stay.
- SETUP: DS/W_Adr held, S_Sel=0. Next state SELECT.
- SELECT: S_Sel=1, W_En=0 (mux output settles). Next state WRITE.
- WRITE: S_Sel=1, W_En=1 for exactly one cycle. Next state RELEASE.
- RELEASE: S_Sel=0, W_En=0, pop head. Next state IDLE.
- DS and W_Adr hold their last value in IDLE; they change only on the IDLE->SETUP edge.
- Latency: go sampled high in IDLE at edge N gives S_Sel high after edges N+2 and N+3, W_En high after edge N+3 only, pop at edge N+4.
- Back-to-back words: 5 cycles per word minimum (RELEASE->IDLE->SETUP).
- go deasserting after IDLE has no effect; a started sequence always completes.
- A push to an empty FIFO while in IDLE becomes visible (empty=0) the next cycle. The load can start no earlier than the cycle after that.
- Reset mid-sequence: W_En and S_Sel drop asynchronously, buffered entries are discarded, no partial write is issued afterwards.
- count never exceeds DEPTH or underflows; there is no pop path outside RELEASE.

Test Plan:
- Reset then idle: all outputs at reset values; go=1 with empty FIFO -> S_Sel and W_En stay 0, busy=0.
- Push {addr=3, data=16'h1234}, then go=1 -> DS=16'h1234 and W_Adr=3 from SETUP. S_Sel=1 for exactly 2 cycles, W_En=1 only in the second of them. count 1->0 after RELEASE.
- Push 4 words A0..A3 (addrs 0..3), then a 5th -> full=1, overflow=1, 5th dropped. With go held high, W_En pulses occur every 5 cycles in order A0,A1,A2,A3 with matching addrs. empty=1 at end.
- Simultaneous push of new word during RELEASE with count=2 -> count stays 2; the word is written in FIFO order after the existing entry.
- Pointer wrap: 6 push/load pairs through a DEPTH=4 FIFO -> data and addresses are correct across the wrap.
- Assert reset during WRITE -> W_En and S_Sel go 0 immediately. Post-reset count=0, empty=1, overflow=0, and no W_En pulse follows.

Source files
------------

// File: rtl/ds_loader.sv
// Buffers externally supplied {addr,data} words and sequences each one onto the
// datapath S-select path: DS settles first, then S_Sel, then a one-cycle W_En.
module ds_loader #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     go,
  output logic [DATA_W-1:0]        DS,
  output logic                     S_Sel,
  output logic                     W_En,
  output logic [ADDR_W-1:0]        W_Adr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, SETUP, SELECT, WRITE, RELEASE} state_t;

  state_t state_q;
  state_t state_nxt;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_nxt;

  logic push;
  logic pop;
  logic load;
  logic s_sel_d;
  logic w_en_d;

  assign push = wr_en && !full;
  assign pop  = (state_q == RELEASE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (!empty && go) state_nxt = SETUP;
      SETUP:   state_nxt = SELECT;
      SELECT:  state_nxt = WRITE;
      WRITE:   state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the current state and registered, so they trail
  // the state by one cycle: S_Sel covers WRITE/RELEASE, W_En only RELEASE.
  always_comb begin
    s_sel_d = 1'b0;
    w_en_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE:    load    = !empty && go;
      SELECT:  s_sel_d = 1'b1;
      WRITE: begin
        s_sel_d = 1'b1;
        w_en_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= wr_data;
        addr_mem[wr_ptr] <= wr_addr;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  // DS/W_Adr only change on the IDLE->SETUP edge, so they are settled well
  // before S_Sel rises and remain put until after it falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DS    <= '0;
      W_Adr <= '0;
      S_Sel <= 1'b0;
      W_En  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      if (load) begin
        DS    <= data_mem[rd_ptr];
        W_Adr <= addr_mem[rd_ptr];
      end
      S_Sel <= s_sel_d;
      W_En  <= w_en_d;
      busy  <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ds_loader.sv
// Directed bench for ds_loader: reset state, single load timing, full/overflow,
// push during RELEASE, pointer wrap and reset in the middle of a sequence.
module tb_ds_loader;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              go;
  logic [DATA_W-1:0] DS;
  logic              S_Sel;
  logic              W_En;
  logic [ADDR_W-1:0] W_Adr;
  logic              full;
  logic              empty;
  logic [2:0]        count;
  logic              busy;
  logic              overflow;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_data [8];
  logic [ADDR_W-1:0] exp_addr [8];

  ds_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_addr(wr_addr), .go(go), .DS(DS), .S_Sel(S_Sel), .W_En(W_En),
    .W_Adr(W_Adr), .full(full), .empty(empty), .count(count),
    .busy(busy), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h required=%0h", tag, obs, expv);
    end
  endtask

  // Push one entry; called right after a falling edge, returns on the next one.
  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic drainCheck(input int n);
    int seen;
    int last;
    seen = 0;
    last = 0;
    go = 1'b1;
    for (int cyc = 0; cyc < n * 5 + 10; cyc++) begin
      @(negedge clk);
      if (W_En) begin
        if (seen < n) begin
          checkOutput("drain_data", 32'(DS), 32'(exp_data[seen]));
          checkOutput("drain_addr", 32'(W_Adr), 32'(exp_addr[seen]));
          checkOutput("drain_ssel", 32'(S_Sel), 32'd1);
        end
        if (seen > 0) checkOutput("drain_gap", 32'(cyc - last), 32'd5);
        last = cyc;
        seen++;
      end
    end
    go = 1'b0;
    checkOutput("drain_pulses", 32'(seen), 32'(n));
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    int pulses;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_addr = '0;
    go      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state, then go with nothing buffered.
    checkOutput("rst_DS", 32'(DS), 32'd0);
    checkOutput("rst_ssel", 32'(S_Sel), 32'd0);
    checkOutput("rst_wen", 32'(W_En), 32'd0);
    checkOutput("rst_wadr", 32'(W_Adr), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_go_ssel", 32'(S_Sel), 32'd0);
      checkOutput("idle_go_wen", 32'(W_En), 32'd0);
      checkOutput("idle_go_busy", 32'(busy), 32'd0);
    end
    go = 1'b0;

    // Single word, cycle-by-cycle timing.
    applyStimulus(3'd3, 16'h1234);
    checkOutput("one_empty", 32'(empty), 32'd0);
    checkOutput("one_count", 32'(count), 32'd1);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checkOutput("setup_busy", 32'(busy), 32'd1);
    checkOutput("setup_DS", 32'(DS), 32'h1234);
    checkOutput("setup_wadr", 32'(W_Adr), 32'd3);
    checkOutput("setup_ssel", 32'(S_Sel), 32'd0);
    @(negedge clk);
    checkOutput("n1_ssel", 32'(S_Sel), 32'd0);
    checkOutput("n1_wen", 32'(W_En), 32'd0);
    @(negedge clk);
    checkOutput("n2_ssel", 32'(S_Sel), 32'd1);
    checkOutput("n2_wen", 32'(W_En), 32'd0);
    @(negedge clk);
    checkOutput("n3_ssel", 32'(S_Sel), 32'd1);
    checkOutput("n3_wen", 32'(W_En), 32'd1);
    checkOutput("n3_count", 32'(count), 32'd1);
    @(negedge clk);
    checkOutput("n4_ssel", 32'(S_Sel), 32'd0);
    checkOutput("n4_wen", 32'(W_En), 32'd0);
    checkOutput("n4_count", 32'(count), 32'd0);
    checkOutput("n4_empty", 32'(empty), 32'd1);
    checkOutput("n4_busy", 32'(busy), 32'd0);
    checkOutput("n4_DS_hold", 32'(DS), 32'h1234);

    // Fill, overflow, then drain in order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'(i), 16'hA000 + 16'(i));
      exp_data[i] = 16'hA000 + 16'(i);
      exp_addr[i] = 3'(i);
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_ovf", 32'(overflow), 32'd0);
    applyStimulus(3'd7, 16'hDEAD);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd4);
    drainCheck(4);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Push during RELEASE with count=2.
    applyStimulus(3'd5, 16'hB000);
    applyStimulus(3'd6, 16'hB001);
    checkOutput("b_count", 32'(count), 32'd2);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("b0_wen", 32'(W_En), 32'd1);
    checkOutput("b0_DS", 32'(DS), 32'hB000);
    wr_addr = 3'd7;
    wr_data = 16'hB002;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    checkOutput("pushpop_count", 32'(count), 32'd2);
    exp_data[0] = 16'hB001; exp_addr[0] = 3'd6;
    exp_data[1] = 16'hB002; exp_addr[1] = 3'd7;
    drainCheck(2);

    // Pointer wrap: six push/load pairs.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'((i + 2) % 8), 16'hC0D0 + 16'(i));
      exp_data[0] = 16'hC0D0 + 16'(i);
      exp_addr[0] = 3'((i + 2) % 8);
      drainCheck(1);
    end

    // Reset while W_En is high; buffered entries must be discarded.
    applyStimulus(3'd1, 16'hD000);
    applyStimulus(3'd2, 16'hD001);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_wen", 32'(W_En), 32'd1);
    checkOutput("pre_rst_ovf", 32'(overflow), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_ssel", 32'(S_Sel), 32'd0);
    checkOutput("async_wen", 32'(W_En), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_count", 32'(count), 32'd0);
    checkOutput("post_empty", 32'(empty), 32'd1);
    checkOutput("post_ovf", 32'(overflow), 32'd0);
    checkOutput("post_busy", 32'(busy), 32'd0);
    pulses = 0;
    go = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (W_En || S_Sel) pulses++;
    end
    go = 1'b0;
    checkOutput("post_no_pulse", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
